// File: rtl/alu_ctrl_datapath_if.sv
// rtl/alu_ctrl_datapath_if.sv - execute-stage bus: instruction/operands in, decode/ALU/PC results out
interface alu_ctrl_datapath_if #(
    parameter int DATA_SIZE = 32,
    parameter int PC_SIZE   = 6
);
    logic [31:0]          instruction;
    logic [DATA_SIZE-1:0] a;
    logic [DATA_SIZE-1:0] b;
    logic [PC_SIZE-1:0]   pc;
    logic [PC_SIZE-1:0]   pc_inc;
    logic [PC_SIZE-1:0]   pc_next;
    logic [2:0]           alu_op;
    logic                 reg_write;
    logic [DATA_SIZE-1:0] result;
    logic                 overflow;
    logic                 zero;
    logic                 flag_overflow;
    logic                 flag_zero;

    modport master (
        output instruction, a, b, pc, pc_inc,
        input  pc_next, alu_op, reg_write, result, overflow, zero, flag_overflow, flag_zero
    );

    modport slave (
        input  instruction, a, b, pc, pc_inc,
        output pc_next, alu_op, reg_write, result, overflow, zero, flag_overflow, flag_zero
    );
endinterface

// File: rtl/alu_ctrl_datapath.sv
// rtl/alu_ctrl_datapath.sv - combinational decode, ALU and PC adder with a registered overflow/zero status pair
module alu_ctrl_datapath #(
    parameter int DATA_SIZE = 32,
    parameter int PC_SIZE   = 6
) (
    input logic                 clk,
    input logic                 rst,
    alu_ctrl_datapath_if.slave  bus
);
    localparam int MSB = DATA_SIZE - 1;

    logic [5:0]           opcode_w;
    logic [5:0]           func_w;
    logic [2:0]           alu_op_c;
    logic                 reg_write_c;
    logic [DATA_SIZE-1:0] sum_w;
    logic [DATA_SIZE-1:0] diff_w;
    logic [DATA_SIZE-1:0] result_c;
    logic                 overflow_c;
    logic                 zero_c;
    logic                 slt_w;
    logic [PC_SIZE-1:0]   pc_next_w;
    logic                 flag_overflow_q, flag_overflow_d;
    logic                 flag_zero_q, flag_zero_d;
    logic                 unused_instr_bits;

    assign opcode_w          = bus.instruction[31:26];
    assign func_w            = bus.instruction[5:0];
    assign unused_instr_bits = ^bus.instruction[25:6];

    // Anything that is not a recognised R-type falls back to ADD with writes disabled.
    always_comb begin
        alu_op_c    = 3'b010;
        reg_write_c = 1'b0;
        if (opcode_w == 6'b000000) begin
            reg_write_c = 1'b1;
            case (func_w)
                6'h20:   alu_op_c = 3'b010;
                6'h22:   alu_op_c = 3'b110;
                6'h24:   alu_op_c = 3'b000;
                6'h25:   alu_op_c = 3'b001;
                6'h26:   alu_op_c = 3'b011;
                6'h27:   alu_op_c = 3'b100;
                6'h2A:   alu_op_c = 3'b111;
                default: reg_write_c = 1'b0;
            endcase
        end
    end

    assign sum_w  = bus.a + bus.b;
    assign diff_w = bus.a - bus.b;
    // Signed compare directly, so SLT stays correct when a-b would overflow.
    assign slt_w  = $signed(bus.a) < $signed(bus.b);

    always_comb begin
        result_c   = '0;
        overflow_c = 1'b0;
        case (alu_op_c)
            3'b000: result_c = bus.a & bus.b;
            3'b001: result_c = bus.a | bus.b;
            3'b010: begin
                result_c   = sum_w;
                overflow_c = (bus.a[MSB] == bus.b[MSB]) && (sum_w[MSB] != bus.a[MSB]);
            end
            3'b110: begin
                result_c   = diff_w;
                overflow_c = (bus.a[MSB] != bus.b[MSB]) && (diff_w[MSB] != bus.a[MSB]);
            end
            3'b011: result_c = bus.a ^ bus.b;
            3'b100: result_c = ~(bus.a | bus.b);
            3'b111: result_c = {{(DATA_SIZE-1){1'b0}}, slt_w};
            default: result_c = '0;
        endcase
    end

    assign zero_c    = (result_c == '0);
    assign pc_next_w = bus.pc + bus.pc_inc;

    always_comb begin
        flag_overflow_d = flag_overflow_q;
        flag_zero_d     = flag_zero_q;
        if (reg_write_c) begin
            flag_overflow_d = overflow_c;
            flag_zero_d     = zero_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_overflow_q <= 1'b0;
            flag_zero_q     <= 1'b0;
        end else begin
            flag_overflow_q <= flag_overflow_d;
            flag_zero_q     <= flag_zero_d;
        end
    end

    assign bus.alu_op        = alu_op_c;
    assign bus.reg_write     = reg_write_c;
    assign bus.result        = result_c;
    assign bus.overflow      = overflow_c;
    assign bus.zero          = zero_c;
    assign bus.pc_next       = pc_next_w;
    assign bus.flag_overflow = flag_overflow_q;
    assign bus.flag_zero     = flag_zero_q;
endmodule

// File: tb/tb_alu_ctrl_datapath.sv
// tb/tb_alu_ctrl_datapath.sv - scoreboard bench for alu_ctrl_datapath
module tb_alu_ctrl_datapath;
    localparam int DW = 32;
    localparam int PW = 6;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    alu_ctrl_datapath_if #(.DATA_SIZE(DW), .PC_SIZE(PW)) bus ();

    alu_ctrl_datapath #(.DATA_SIZE(DW), .PC_SIZE(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic        rw;
        logic [31:0] res;
        logic        ov;
        logic        z;
    } comb_t;

    comb_t       comb_q[$];
    logic [1:0]  flag_q[$];
    logic [5:0]  pc_q[$];

    function automatic logic [31:0] rtype(input logic [5:0] f);
        return {6'd0, 20'd0, f};
    endfunction

    // Independent reference: decode table plus 64-bit signed arithmetic.
    function automatic comb_t model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        comb_t  e;
        longint sa;
        longint sb;
        longint s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        s  = 0;
        e.op = 3'b010; e.rw = 1'b0; e.ov = 1'b0; e.res = 32'd0;
        if (ins[31:26] == 6'd0) begin
            case (ins[5:0])
                6'h20: begin e.op = 3'b010; e.rw = 1'b1; end
                6'h22: begin e.op = 3'b110; e.rw = 1'b1; end
                6'h24: begin e.op = 3'b000; e.rw = 1'b1; end
                6'h25: begin e.op = 3'b001; e.rw = 1'b1; end
                6'h26: begin e.op = 3'b011; e.rw = 1'b1; end
                6'h27: begin e.op = 3'b100; e.rw = 1'b1; end
                6'h2A: begin e.op = 3'b111; e.rw = 1'b1; end
                default: ;
            endcase
        end
        case (e.op)
            3'b010: begin s = sa + sb; e.res = s[31:0]; e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            3'b110: begin s = sa - sb; e.res = s[31:0]; e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            3'b000: e.res = a & b;
            3'b001: e.res = a | b;
            3'b011: e.res = a ^ b;
            3'b100: e.res = ~(a | b);
            3'b111: e.res = (sa < sb) ? 32'd1 : 32'd0;
            default: e.res = 32'd0;
        endcase
        e.z = (e.res == 32'd0);
        return e;
    endfunction

    task automatic drive(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        bus.instruction = ins;
        bus.a           = a;
        bus.b           = b;
    endtask

    task automatic test_reset();
        logic [1:0] e;
        rst = 1'b1;
        drive(rtype(6'h20), 32'h8000_0000, 32'h8000_0000);
        bus.pc = 6'd0; bus.pc_inc = 6'd1;
        #1;
        checks++;
        if ({bus.flag_overflow, bus.flag_zero} !== 2'b00) begin
            failures++; $display("FAIL reset_state got=%b want=00", {bus.flag_overflow, bus.flag_zero});
        end
        @(negedge clk); rst = 1'b0;
        flag_q.push_back(2'b11);
        @(posedge clk); #1;
        e = flag_q.pop_front(); checks++;
        if ({bus.flag_overflow, bus.flag_zero} !== e) begin
            failures++; $display("FAIL preload_flags got=%b want=%b", {bus.flag_overflow, bus.flag_zero}, e);
        end
        @(negedge clk); rst = 1'b1; #1;
        checks++;
        if ({bus.flag_overflow, bus.flag_zero} !== 2'b00) begin
            failures++; $display("FAIL async_clear got=%b want=00", {bus.flag_overflow, bus.flag_zero});
        end
        @(posedge clk); #1;
        checks++;
        if ({bus.flag_overflow, bus.flag_zero} !== 2'b00) begin
            failures++; $display("FAIL reset_hold got=%b want=00", {bus.flag_overflow, bus.flag_zero});
        end
        @(negedge clk); rst = 1'b0;
        drive(rtype(6'h20), 32'd0, 32'd0);
        flag_q.push_back(2'b01);
        @(posedge clk); #1;
        e = flag_q.pop_front(); checks++;
        if ({bus.flag_overflow, bus.flag_zero} !== e) begin
            failures++; $display("FAIL post_reset_load got=%b want=%b", {bus.flag_overflow, bus.flag_zero}, e);
        end
    endtask

    task automatic test_decode();
        logic [31:0] ins_t[9];
        logic [2:0]  op_t[9];
        logic        rw_t[9];
        comb_t       e;
        ins_t = '{rtype(6'h20), rtype(6'h22), rtype(6'h24), rtype(6'h25), rtype(6'h26),
                  rtype(6'h27), rtype(6'h2A), rtype(6'h08), {6'h23, 20'd0, 6'h20}};
        op_t  = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b011, 3'b100, 3'b111, 3'b010, 3'b010};
        rw_t  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive(ins_t[i], 32'd7, 32'd3);
            e.op = op_t[i]; e.rw = rw_t[i]; e.res = 32'd0; e.ov = 1'b0; e.z = 1'b0;
            comb_q.push_back(e);
            #1;
            e = comb_q.pop_front(); checks++;
            if (bus.alu_op !== e.op || bus.reg_write !== e.rw) begin
                failures++;
                $display("FAIL decode[%0d] got op=%b rw=%b want op=%b rw=%b", i, bus.alu_op, bus.reg_write, e.op, e.rw);
            end
        end
    endtask

    task automatic test_alu();
        logic [31:0] ins_t[14];
        logic [31:0] a_t[14];
        logic [31:0] b_t[14];
        logic [31:0] r_t[14];
        logic        ov_t[14];
        comb_t       e;
        ins_t = '{rtype(6'h20), rtype(6'h22), rtype(6'h22), rtype(6'h20), rtype(6'h22),
                  rtype(6'h24), rtype(6'h27), rtype(6'h2A), rtype(6'h2A), rtype(6'h2A),
                  rtype(6'h2A), rtype(6'h25), rtype(6'h26), rtype(6'h20)};
        a_t   = '{32'h7FFF_FFFF, 32'h8000_0000, 32'd5, 32'hFFFF_FFFF, 32'h7FFF_FFFF,
                  32'hF0F0_F0F0, 32'd0, 32'hFFFF_FFFF, 32'h8000_0000, 32'd3,
                  32'h7FFF_FFFF, 32'h0000_000F, 32'h0000_00FF, 32'h8000_0000};
        b_t   = '{32'd1, 32'd1, 32'd5, 32'd1, 32'hFFFF_FFFF,
                  32'hFF00_FF00, 32'd0, 32'd1, 32'h7FFF_FFFF, 32'd3,
                  32'h8000_0000, 32'h0000_00F0, 32'h0000_000F, 32'hFFFF_FFFF};
        r_t   = '{32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 32'd0, 32'h8000_0000,
                  32'hF000_F000, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd0,
                  32'd0, 32'h0000_00FF, 32'h0000_00F0, 32'h7FFF_FFFF};
        ov_t  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(ins_t[i], a_t[i], b_t[i]);
            e.op = 3'b000; e.rw = 1'b1; e.res = r_t[i]; e.ov = ov_t[i]; e.z = (r_t[i] == 32'd0);
            comb_q.push_back(e);
            #1;
            e = comb_q.pop_front(); checks++;
            if (bus.result !== e.res || bus.overflow !== e.ov || bus.zero !== e.z) begin
                failures++;
                $display("FAIL alu[%0d] got res=%h ov=%b z=%b want res=%h ov=%b z=%b",
                         i, bus.result, bus.overflow, bus.zero, e.res, e.ov, e.z);
            end
        end
    endtask

    task automatic test_pc();
        logic [5:0] pc_t[4];
        logic [5:0] inc_t[4];
        logic [5:0] exp_t[4];
        logic [5:0] e;
        pc_t  = '{6'd5, 6'd63, 6'd62, 6'd0};
        inc_t = '{6'd1, 6'd1, 6'd3, 6'd0};
        exp_t = '{6'd6, 6'd0, 6'd1, 6'd0};
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            bus.pc = pc_t[i]; bus.pc_inc = inc_t[i];
            pc_q.push_back(exp_t[i]);
            #1;
            e = pc_q.pop_front(); checks++;
            if (bus.pc_next !== e) begin
                failures++; $display("FAIL pc_next[%0d] got=%0d want=%0d", i, bus.pc_next, e);
            end
        end
    endtask

    task automatic test_flag_hold();
        logic [1:0] e;
        @(negedge clk);
        drive(rtype(6'h20), 32'h7FFF_FFFF, 32'd1);
        flag_q.push_back(2'b10);
        @(posedge clk); #1;
        e = flag_q.pop_front(); checks++;
        if ({bus.flag_overflow, bus.flag_zero} !== e) begin
            failures++; $display("FAIL flag_load got=%b want=%b", {bus.flag_overflow, bus.flag_zero}, e);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive({6'h23, 20'd0, 6'h20}, 32'd0, 32'd0);
            flag_q.push_back(2'b10);
            @(posedge clk); #1;
            e = flag_q.pop_front(); checks++;
            if ({bus.flag_overflow, bus.flag_zero} !== e) begin
                failures++; $display("FAIL flag_hold[%0d] got=%b want=%b", i, {bus.flag_overflow, bus.flag_zero}, e);
            end
        end
        @(negedge clk);
        drive(rtype(6'h08), 32'd0, 32'd0);
        flag_q.push_back(2'b10);
        @(posedge clk); #1;
        e = flag_q.pop_front(); checks++;
        if ({bus.flag_overflow, bus.flag_zero} !== e) begin
            failures++; $display("FAIL flag_hold_badfunc got=%b want=%b", {bus.flag_overflow, bus.flag_zero}, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0]  funcs[9];
        logic [31:0] corners[6];
        logic [31:0] ins;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  mflags;
        logic [1:0]  ef;
        comb_t       e;
        funcs   = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h08, 6'h3F};
        corners = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h1234_5678};
        mflags  = {bus.flag_overflow, bus.flag_zero};
        mflags  = 2'b10;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            ins = rtype(funcs[$urandom_range(0, 8)]);
            if ($urandom_range(0, 7) == 0) ins[31:26] = 6'($urandom_range(1, 63));
            a = ($urandom_range(0, 1) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            b = ($urandom_range(0, 1) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            drive(ins, a, b);
            e = model(ins, a, b);
            comb_q.push_back(e);
            if (e.rw) mflags = {e.ov, e.z};
            flag_q.push_back(mflags);
            #1;
            e = comb_q.pop_front(); checks++;
            if (bus.alu_op !== e.op || bus.reg_write !== e.rw || bus.result !== e.res ||
                bus.overflow !== e.ov || bus.zero !== e.z) begin
                failures++;
                $display("FAIL b2b[%0d] ins=%h a=%h b=%h got op=%b rw=%b res=%h ov=%b z=%b want op=%b rw=%b res=%h ov=%b z=%b",
                         i, ins, a, b, bus.alu_op, bus.reg_write, bus.result, bus.overflow, bus.zero,
                         e.op, e.rw, e.res, e.ov, e.z);
            end
            @(posedge clk); #1;
            ef = flag_q.pop_front(); checks++;
            if ({bus.flag_overflow, bus.flag_zero} !== ef) begin
                failures++; $display("FAIL b2b_flags[%0d] got=%b want=%b", i, {bus.flag_overflow, bus.flag_zero}, ef);
            end
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_alu();
        test_pc();
        test_flag_hold();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
